// File: rtl/pwm_regbank_pkg.sv
// pwm_regbank_pkg
//   Shared constants for the multi-channel PWM register bank:
//   word addresses, per-channel register offsets and CTRL bit positions.
package pwm_regbank_pkg;

    // Global register word addresses
    localparam int unsigned ADDR_CTRL    = 32'h00;
    localparam int unsigned ADDR_PRESC   = 32'h01;
    localparam int unsigned ADDR_STATUS  = 32'h02;
    localparam int unsigned ADDR_IRQMASK = 32'h03;
    localparam int unsigned ADDR_SWUPD   = 32'h04;
    localparam int unsigned ADDR_DTEN    = 32'h05;

    // Channel c lives at CH_BASE + CH_STRIDE*c
    localparam int unsigned CH_BASE      = 32'h10;
    localparam int unsigned CH_STRIDE    = 4;

    // CTRL bit indices
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE    = 1;
    localparam int unsigned CTRL_PRELOAD = 2;
    localparam int unsigned CTRL_LOCK    = 3;

    // Register offset within a channel block
    typedef enum logic [1:0] {
        CH_PERIOD = 2'd0,
        CH_DUTY1  = 2'd1,
        CH_DUTY2  = 2'd2,
        CH_DTVAL  = 2'd3
    } ch_reg_e;

endpackage

// File: rtl/pwm_ch_shadow.sv
// pwm_ch_shadow
//   One PWM channel's double-buffered registers: shadow and active copies of
//   period, duty1, duty2, deadtime value and deadtime enable, the pending bit
//   and the commit decision.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_wr_en/i_wr_sel  shadow write strobe and register select for this channel
//   i_wr_data         write data
//   i_dten_wr/_val    shadow deadtime-enable write strobe and value
//   i_preload_en      1: commit only on i_upd_evt; 0: commit right after a write
//   i_upd_evt         counter-overflow pulse from the core
//   i_swupd           software-forced commit
//   o_sh_*            shadow values (register readback)
//   o_period..o_dten  active values driven to the PWM core
//   o_commit          commit happens at the coming edge (feeds status)
module pwm_ch_shadow
    import pwm_regbank_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  ch_reg_e          i_wr_sel,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_dten_wr,
    input  logic             i_dten_val,
    input  logic             i_preload_en,
    input  logic             i_upd_evt,
    input  logic             i_swupd,
    output logic [WIDTH-1:0] o_sh_period,
    output logic [WIDTH-1:0] o_sh_duty1,
    output logic [WIDTH-1:0] o_sh_duty2,
    output logic [WIDTH-1:0] o_sh_dtval,
    output logic             o_sh_dten,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_duty1,
    output logic [WIDTH-1:0] o_duty2,
    output logic [WIDTH-1:0] o_dtval,
    output logic             o_dten,
    output logic             o_commit
);

    logic [WIDTH-1:0] r_sh_period, r_sh_duty1, r_sh_duty2, r_sh_dtval;
    logic [WIDTH-1:0] r_act_period, r_act_duty1, r_act_duty2, r_act_dtval;
    logic             r_sh_dten, r_act_dten;
    logic             r_pending;
    logic             w_sh_write;
    logic             w_commit;

    assign w_sh_write = i_wr_en | i_dten_wr;

    // Without preload a pending write commits on the very next edge; with
    // preload it waits for the core's update event. Software update always wins.
    assign w_commit = i_swupd | (r_pending & (~i_preload_en | i_upd_evt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_period  <= '0;
            r_sh_duty1   <= '0;
            r_sh_duty2   <= '0;
            r_sh_dtval   <= '0;
            r_sh_dten    <= 1'b0;
            r_act_period <= '0;
            r_act_duty1  <= '0;
            r_act_duty2  <= '0;
            r_act_dtval  <= '0;
            r_act_dten   <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            if (i_wr_en) begin
                case (i_wr_sel)
                    CH_PERIOD: r_sh_period <= i_wr_data;
                    CH_DUTY1:  r_sh_duty1  <= i_wr_data;
                    CH_DUTY2:  r_sh_duty2  <= i_wr_data;
                    CH_DTVAL:  r_sh_dtval  <= i_wr_data;
                endcase
            end
            if (i_dten_wr) begin
                r_sh_dten <= i_dten_val;
            end
            // Active copy takes the pre-write shadow when a write coincides
            // with a commit; the write then keeps pending set for next time.
            if (w_commit) begin
                r_act_period <= r_sh_period;
                r_act_duty1  <= r_sh_duty1;
                r_act_duty2  <= r_sh_duty2;
                r_act_dtval  <= r_sh_dtval;
                r_act_dten   <= r_sh_dten;
            end
            if (w_sh_write) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_sh_period = r_sh_period;
    assign o_sh_duty1  = r_sh_duty1;
    assign o_sh_duty2  = r_sh_duty2;
    assign o_sh_dtval  = r_sh_dtval;
    assign o_sh_dten   = r_sh_dten;
    assign o_period    = r_act_period;
    assign o_duty1     = r_act_duty1;
    assign o_duty2     = r_act_duty2;
    assign o_dtval     = r_act_dtval;
    assign o_dten      = r_act_dten;
    assign o_commit    = w_commit;

endmodule

// File: rtl/pwm_regbank.sv
// pwm_regbank
//   Multi-channel PWM register bank: global CTRL/PRESC, sticky W1C STATUS,
//   IRQ_MASK, SWUPD and DTEN, plus NUM_CH double-buffered channel blocks.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   wr_en, rd_en, addr    bus strobes and word address
//   wr_data, rd_data      write data / registered read data (0 when idle)
//   rd_valid              pulse one cycle after rd_en
//   upd_evt[NUM_CH]       per-channel overflow pulses from the cores
//   en, mode              CTRL[0], CTRL[1]
//   prescaler_div         immediate prescaler value
//   period..deadtime_val  active per-channel values, channel i at [i*WIDTH +: WIDTH]
//   deadtime_en           active per-channel deadtime enables
//   irq                   registered |(status & irq_mask)
module pwm_regbank
    import pwm_regbank_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    input  logic [NUM_CH-1:0]       upd_evt,
    output logic                    en,
    output logic                    mode,
    output logic [WIDTH-1:0]        prescaler_div,
    output logic [NUM_CH*WIDTH-1:0] period,
    output logic [NUM_CH*WIDTH-1:0] duty1,
    output logic [NUM_CH*WIDTH-1:0] duty2,
    output logic [NUM_CH*WIDTH-1:0] deadtime_val,
    output logic [NUM_CH-1:0]       deadtime_en,
    output logic                    irq
);

    logic               r_en, r_mode, r_preload, r_lock;
    logic [WIDTH-1:0]   r_presc;
    logic [NUM_CH-1:0]  r_status, r_irq_mask;
    logic               r_irq;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_rd_valid;

    logic [31:0]        w_addr;
    logic               w_hit_ctrl, w_hit_presc, w_hit_status, w_hit_mask;
    logic               w_hit_swupd, w_hit_dten, w_is_ch;
    logic [3:0]         w_ch_idx;
    ch_reg_e            w_ch_reg;
    logic [NUM_CH-1:0]  w_wr_bits;
    logic [NUM_CH-1:0]  w_swupd, w_w1c, w_commit, w_ch_wr;
    logic               w_cfg_wr;
    logic [NUM_CH-1:0]  w_sh_dten;
    logic [WIDTH-1:0]   w_sh_period [NUM_CH];
    logic [WIDTH-1:0]   w_sh_duty1  [NUM_CH];
    logic [WIDTH-1:0]   w_sh_duty2  [NUM_CH];
    logic [WIDTH-1:0]   w_sh_dtval  [NUM_CH];
    logic [WIDTH-1:0]   w_rd_mux;

    // Address decode done at 32 bits so the top of the channel window cannot
    // wrap when it sits exactly at 2^ADDR_W.
    assign w_addr       = 32'(addr);
    assign w_hit_ctrl   = (w_addr == ADDR_CTRL);
    assign w_hit_presc  = (w_addr == ADDR_PRESC);
    assign w_hit_status = (w_addr == ADDR_STATUS);
    assign w_hit_mask   = (w_addr == ADDR_IRQMASK);
    assign w_hit_swupd  = (w_addr == ADDR_SWUPD);
    assign w_hit_dten   = (w_addr == ADDR_DTEN);
    assign w_is_ch      = (w_addr >= CH_BASE) && (w_addr < CH_BASE + CH_STRIDE * NUM_CH);
    assign w_ch_idx     = 4'((w_addr - CH_BASE) >> 2);
    assign w_ch_reg     = ch_reg_e'(addr[1:0]);

    assign w_wr_bits = NUM_CH'(wr_data);
    assign w_cfg_wr  = wr_en & ~r_lock;
    assign w_swupd   = (wr_en & w_hit_swupd)  ? w_wr_bits : '0;
    assign w_w1c     = (wr_en & w_hit_status) ? w_wr_bits : '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_ch_wr[c] = w_cfg_wr & w_is_ch & (w_ch_idx == 4'(c));

        pwm_ch_shadow #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_wr_en      (w_ch_wr[c]),
            .i_wr_sel     (w_ch_reg),
            .i_wr_data    (wr_data),
            .i_dten_wr    (w_cfg_wr & w_hit_dten),
            .i_dten_val   (w_wr_bits[c]),
            .i_preload_en (r_preload),
            .i_upd_evt    (upd_evt[c]),
            .i_swupd      (w_swupd[c]),
            .o_sh_period  (w_sh_period[c]),
            .o_sh_duty1   (w_sh_duty1[c]),
            .o_sh_duty2   (w_sh_duty2[c]),
            .o_sh_dtval   (w_sh_dtval[c]),
            .o_sh_dten    (w_sh_dten[c]),
            .o_period     (period[c*WIDTH +: WIDTH]),
            .o_duty1      (duty1[c*WIDTH +: WIDTH]),
            .o_duty2      (duty2[c*WIDTH +: WIDTH]),
            .o_dtval      (deadtime_val[c*WIDTH +: WIDTH]),
            .o_dten       (deadtime_en[c]),
            .o_commit     (w_commit[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_mode     <= 1'b0;
            r_preload  <= 1'b0;
            r_lock     <= 1'b0;
            r_presc    <= '0;
            r_status   <= '0;
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_cfg_wr & w_hit_ctrl) begin
                r_en      <= wr_data[CTRL_EN];
                r_mode    <= wr_data[CTRL_MODE];
                r_preload <= wr_data[CTRL_PRELOAD];
                // Only reachable while unlocked, so this can only set lock.
                r_lock    <= wr_data[CTRL_LOCK];
            end
            if (w_cfg_wr & w_hit_presc) begin
                r_presc <= wr_data;
            end
            if (wr_en & w_hit_mask) begin
                r_irq_mask <= w_wr_bits;
            end
            // A commit in the same cycle as W1C keeps the bit set.
            r_status <= (r_status & ~w_w1c) | w_commit;
            r_irq    <= |(r_status & r_irq_mask);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_hit_ctrl) begin
            w_rd_mux = WIDTH'({r_lock, r_preload, r_mode, r_en});
        end else if (w_hit_presc) begin
            w_rd_mux = r_presc;
        end else if (w_hit_status) begin
            w_rd_mux = WIDTH'(r_status);
        end else if (w_hit_mask) begin
            w_rd_mux = WIDTH'(r_irq_mask);
        end else if (w_hit_dten) begin
            w_rd_mux = WIDTH'(w_sh_dten);
        end else if (w_is_ch) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (w_ch_idx == 4'(c)) begin
                    case (w_ch_reg)
                        CH_PERIOD: w_rd_mux = w_sh_period[c];
                        CH_DUTY1:  w_rd_mux = w_sh_duty1[c];
                        CH_DUTY2:  w_rd_mux = w_sh_duty2[c];
                        CH_DTVAL:  w_rd_mux = w_sh_dtval[c];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_data  <= rd_en ? w_rd_mux : '0;
        end
    end

    assign rd_data       = r_rd_data;
    assign rd_valid      = r_rd_valid;
    assign en            = r_en;
    assign mode          = r_mode;
    assign prescaler_div = r_presc;
    assign irq           = r_irq;

endmodule

// File: tb/tb_pwm_regbank.sv
module tb_pwm_regbank;

    localparam int W   = 16;
    localparam int NCH = 4;
    localparam int AW  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [W-1:0]      wr_data = '0;
    logic [NCH-1:0]    upd_evt = '0;
    logic [W-1:0]      rd_data;
    logic              rd_valid;
    logic              en, mode, irq;
    logic [W-1:0]      prescaler_div;
    logic [NCH*W-1:0]  period, duty1, duty2, deadtime_val;
    logic [NCH-1:0]    deadtime_en;

    pwm_regbank #(
        .WIDTH (W),
        .NUM_CH(NCH),
        .ADDR_W(AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .addr         (addr),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .upd_evt      (upd_evt),
        .en           (en),
        .mode         (mode),
        .prescaler_div(prescaler_div),
        .period       (period),
        .duty1        (duty1),
        .duty2        (duty2),
        .deadtime_val (deadtime_val),
        .deadtime_en  (deadtime_en),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (register-map level) ----------------
    logic           m_en = 0, m_mode = 0, m_pre = 0, m_lock = 0;
    logic [W-1:0]   m_presc = '0;
    logic [NCH-1:0] m_status = '0, m_mask = '0, m_pend = '0;
    logic [NCH-1:0] m_sh_dten = '0, m_ac_dten = '0;
    logic [W-1:0]   m_sh [NCH][4];
    logic [W-1:0]   m_ac [NCH][4];
    logic           m_irq = 0, m_rdv = 0;
    logic [W-1:0]   exp_q [$];

    function automatic logic [W-1:0] m_read(int a);
        if (a == 0) return W'({m_lock, m_pre, m_mode, m_en});
        if (a == 1) return m_presc;
        if (a == 2) return W'(m_status);
        if (a == 3) return W'(m_mask);
        if (a == 5) return W'(m_sh_dten);
        if (a >= 16 && a < 16 + 4 * NCH) return m_sh[(a - 16) / 4][(a - 16) % 4];
        return '0;
    endfunction

    task automatic m_reset();
        m_en = 0; m_mode = 0; m_pre = 0; m_lock = 0;
        m_presc = '0; m_status = '0; m_mask = '0; m_pend = '0;
        m_sh_dten = '0; m_ac_dten = '0; m_irq = 0; m_rdv = 0;
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++) begin
                m_sh[c][r] = '0;
                m_ac[c][r] = '0;
            end
        exp_q.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else begin : mdl
            int a;
            logic [NCH-1:0] cm, sw, w1c;
            logic nirq;
            a = int'(addr);
            m_rdv = rd_en;
            if (rd_en) exp_q.push_back(m_read(a));
            sw   = (wr_en && a == 4) ? wr_data[NCH-1:0] : '0;
            w1c  = (wr_en && a == 2) ? wr_data[NCH-1:0] : '0;
            nirq = |(m_status & m_mask);
            for (int c = 0; c < NCH; c++) begin
                cm[c] = sw[c] || (m_pend[c] && (!m_pre || upd_evt[c]));
                if (cm[c]) begin
                    for (int r = 0; r < 4; r++) m_ac[c][r] = m_sh[c][r];
                    m_ac_dten[c] = m_sh_dten[c];
                    m_pend[c] = 1'b0;
                end
            end
            m_status = (m_status & ~w1c) | cm;
            if (wr_en) begin
                if (a == 3) m_mask = wr_data[NCH-1:0];
                if (!m_lock) begin
                    if (a == 0) {m_lock, m_pre, m_mode, m_en} = wr_data[3:0];
                    if (a == 1) m_presc = wr_data;
                    if (a == 5) begin
                        m_sh_dten = wr_data[NCH-1:0];
                        m_pend = '1;
                    end
                    if (a >= 16 && a < 16 + 4 * NCH) begin
                        m_sh[(a - 16) / 4][(a - 16) % 4] = wr_data;
                        m_pend[(a - 16) / 4] = 1'b1;
                    end
                end
            end
            m_irq = nirq;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : mon
        logic [NCH*W-1:0] ep, ed1, ed2, edt;
        for (int c = 0; c < NCH; c++) begin
            ep [c*W +: W] = m_ac[c][0];
            ed1[c*W +: W] = m_ac[c][1];
            ed2[c*W +: W] = m_ac[c][2];
            edt[c*W +: W] = m_ac[c][3];
        end
        chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h expected no read at %0t", rd_data, $time);
            end else begin
                chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
            end
        end else begin
            chk("rd_data_idle", 64'(rd_data), 64'd0);
        end
        chk("en",          64'(en),            64'(m_en));
        chk("mode",        64'(mode),          64'(m_mode));
        chk("presc",       64'(prescaler_div), 64'(m_presc));
        chk("irq",         64'(irq),           64'(m_irq));
        chk("dt_en",       64'(deadtime_en),   64'(m_ac_dten));
        chk("period",      64'(period),        64'(ep));
        chk("duty1",       64'(duty1),         64'(ed1));
        chk("duty2",       64'(duty2),         64'(ed2));
        chk("dtval",       64'(deadtime_val),  64'(edt));
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic w, input logic r, input int a,
                        input logic [W-1:0] d, input logic [NCH-1:0] ev);
        wr_en = w; rd_en = r; addr = AW'(a); wr_data = d; upd_evt = ev;
        @(negedge clk);
        wr_en = 0; rd_en = 0; upd_evt = '0;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        step(1'b1, 1'b0, a, d, '0);
    endtask

    task automatic rd(input int a);
        step(1'b0, 1'b1, a, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, '0, '0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset readback of every mapped address
        for (int a = 0; a < 6; a++) rd(a);
        for (int a = 16; a < 16 + 4 * NCH; a++) rd(a);
        idle(1);
        chk("reset_irq", 64'(irq), 64'd0);

        // no preload: ch2 PERIOD commits on the next edge
        wr(0, 16'h0001);
        wr(16 + 8, 16'h0100);
        idle(1);
        chk("t2_period2", 64'(period[2*W +: W]), 64'h0100);
        rd(2);
        wr(2, 16'h000F);

        // preload: ch1 DUTY1 waits for upd_evt[1]
        wr(0, 16'h0005);
        wr(16 + 4 + 1, 16'h0040);
        idle(1);
        chk("t3_duty1_hold", 64'(duty1[1*W +: W]), 64'h0);
        step(1'b0, 1'b0, 0, '0, 4'b0010);
        chk("t3_duty1_upd", 64'(duty1[1*W +: W]), 64'h0040);
        wr(2, 16'h000F);
        step(1'b0, 1'b0, 0, '0, 4'b0010);
        rd(2);

        // write and upd_evt on ch0 in the same cycle
        wr(16 + 2, 16'h0008);
        step(1'b1, 1'b0, 16 + 2, 16'h0010, 4'b0001);
        chk("t4_duty2_old", 64'(duty2[0 +: W]), 64'h0008);
        step(1'b0, 1'b0, 0, '0, 4'b0001);
        chk("t4_duty2_new", 64'(duty2[0 +: W]), 64'h0010);

        // irq, W1C racing a new commit
        wr(2, 16'h000F);
        idle(1);
        wr(3, 16'h0001);
        wr(4, 16'h0001);
        idle(1);
        chk("t5_irq_set", 64'(irq), 64'd1);
        wr(16, 16'h0005);
        step(1'b1, 1'b0, 2, 16'h0001, 4'b0001);
        idle(2);
        chk("t5_irq_hold", 64'(irq), 64'd1);
        wr(2, 16'h0001);
        idle(1);
        chk("t5_irq_clr", 64'(irq), 64'd0);

        // randomized traffic with a mid-run asynchronous reset
        for (int i = 0; i < 1500; i++) begin : rnd
            int sel, a;
            logic [W-1:0] d;
            sel = int'($urandom_range(0, 9));
            if (sel < 3)      a = int'($urandom_range(0, 5));
            else if (sel < 9) a = int'($urandom_range(16, 16 + 4 * NCH - 1));
            else              a = (($urandom_range(0, 1) == 0) ? int'($urandom_range(6, 15))
                                                                : int'($urandom_range(32, 255)));
            d = W'($urandom);
            if (a == 0) d = d & ~W'(16'h0008);
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), a, d,
                 NCH'($urandom_range(0, 15) & $urandom_range(0, 15)));
            if (i == 750) pulse_reset();
        end

        // lock: configuration frozen, SWUPD still commits, reset unlocks
        wr(16, 16'h1234);
        wr(0, 16'h000D);
        wr(16, 16'hFFFF);
        wr(0, 16'h0000);
        rd(0);
        rd(16);
        chk("t6_lock_en", 64'(en), 64'd1);
        wr(4, 16'h0001);
        chk("t6_swupd_period", 64'(period[0 +: W]), 64'h1234);
        pulse_reset();
        rd(0);
        chk("t6_reset_en", 64'(en), 64'd0);
        wr(0, 16'h0001);
        chk("t6_unlocked_en", 64'(en), 64'd1);

        idle(3);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_regbank.md
# pwm_regbank

Parametrised multi-channel register bank for the PWM subsystem. It extends the single-channel control register block to `NUM_CH` channels. Each channel has double-buffered (preload) period, duty and deadtime registers that commit to the PWM cores on an update event. The bank also provides a sticky update-status register with write-1-to-clear, an interrupt mask and output, and a one-way configuration lock. It sits between the bus-slave front end and the `NUM_CH` PWM cores.

## Interface
- `WIDTH`, 16, data and register width; minimum 8.
- `NUM_CH`, 4, channel count, 1..16.
- `ADDR_W`, 8, word-address width; must satisfy 0x10 + 4·NUM_CH ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe, one word per cycle.
- `rd_en`  in  1  read request.
- `addr`  in  ADDR_W  word address.
- `wr_data`  in  WIDTH  write data.
- `rd_data`  out  WIDTH  registered read data; 0 when `rd_valid`=0.
- `rd_valid`  out  1  one-cycle pulse, the cycle after `rd_en`.
- `upd_evt`  in  NUM_CH  per-channel counter-overflow pulse from the cores.
- `en`  out  1  global enable (CTRL[0]).
- `mode`  out  1  CTRL[1].
- `prescaler_div`  out  WIDTH  immediate, not preloaded.
- `period`, `duty1`, `duty2`, `deadtime_val`  out  NUM_CH·WIDTH  active values; channel i occupies `[i*WIDTH +: WIDTH]`.
- `deadtime_en`  out  NUM_CH  active per-channel deadtime enables.
- `irq`  out  1  `|(status & irq_mask)`, registered.

## Operation
- Address map:
  - 0x00 CTRL: en[0], mode[1], preload_en[2], lock[3]. Lock is set-only.
  - 0x01 PRESC.
  - 0x02 STATUS: bits [NUM_CH-1:0], write-1-to-clear.
  - 0x03 IRQ_MASK.
  - 0x04 SWUPD: write bit i forces a commit on channel i; reads 0.
  - 0x05 DTEN: shadow deadtime enables.
  - Channel c at 0x10+4c: +0 PERIOD, +1 DUTY1, +2 DUTY2, +3 DTVAL.
  - Unmapped addresses: writes ignored, reads 0.
  - Bits above `NUM_CH` in STATUS, IRQ_MASK, SWUPD and DTEN read 0.
- Channel writes and DTEN writes go to the shadow register and set that channel's `pending` bit. Reads return shadow values.
- Commit on channel i: the active registers load the shadow registers, `pending[i]` clears and `status[i]` sets. A commit happens when:
  - preload_en=0: the edge after any shadow write to channel i;
  - preload_en=1: `upd_evt[i]` with `pending[i]`=1;
  - SWUPD bit i written: regardless of preload_en or pending.
- `upd_evt[i]` with `pending[i]`=0 does nothing; status is not set.
- Lock=1:
  - writes to CTRL, PRESC, DTEN and the channel registers are ignored;
  - STATUS, IRQ_MASK and SWUPD remain writable;
  - only `rst_n` clears lock.
- Reset values: every register, output, pending bit, `rd_data`, `rd_valid` and `irq` is 0.

## Timing
- Write: the shadow value is visible from the cycle after `wr_en`.
- Active outputs, preload_en=0: change 1 cycle after the write.
- Active outputs, preload_en=1: change 1 cycle after the `upd_evt` (or SWUPD write) edge.
- Read latency is 1 cycle. When `rd_en` and `wr_en` target the same address in the same cycle, the read returns the pre-write value.
- Shadow write and `upd_evt[i]` in the same cycle: the active registers take the pre-write shadow and `pending[i]` stays 1. The new value commits on the next event.
- `status[i]` set and W1C in the same cycle: set wins.
- `irq` follows status and mask with 1 cycle of latency.
- `rst_n` asserted mid-operation: everything clears asynchronously, including pending writes, which are discarded.

## Structure
- Package `pwm_regbank_pkg` holds:
  - address constants: `ADDR_CTRL`, `ADDR_PRESC`, `ADDR_STATUS`, `ADDR_IRQMASK`, `ADDR_SWUPD`, `ADDR_DTEN`, `CH_BASE`, `CH_STRIDE`;
  - channel register offsets;
  - CTRL bit indices.
- Sub-module `pwm_ch_shadow`, instantiated `NUM_CH` times. It holds:
  - shadow and active period, duty1, duty2, dtval and dt_en;
  - the pending bit;
  - the commit logic;
  - output `commit` for the status logic.

## Test plan
- Reset, then read every mapped address → all 0; `irq`=0; `rd_valid` pulses one cycle after each `rd_en`.
- preload_en=0, write ch2 PERIOD=0x0100 → `period[2]`=0x0100 the next cycle; `status[2]`=1.
- preload_en=1, write ch1 DUTY1=0x0040 → `duty1[1]` unchanged. Pulse `upd_evt[1]` → 0x0040 the next cycle. A second `upd_evt[1]` leaves status unchanged after W1C.
- preload_en=1, write ch0 DUTY2=0x10 and pulse `upd_evt[0]` in the same cycle → active stays at the old value. The next `upd_evt[0]` → 0x10.
- IRQ_MASK=0x1, force a ch0 commit → `irq`=1. W1C STATUS=0x1 in the same cycle as a new commit → status stays 1. A W1C with no new commit → `irq`=0 one cycle later.
- Set lock; write PERIOD ch0=0xFFFF and CTRL=0 → both ignored, readback unchanged. An SWUPD write still commits. Assert `rst_n` → lock=0.
